// File: rtl/hc_rd_stream_requestor_pkg.sv
// Shared types for the HardCloud read requestor: request control, simplified
// CCI-P c0 channel structs, read FSM states and the line-address helper.
package hc_rd_stream_requestor_pkg;

    localparam int HC_RD_MAX_OUTSTANDING = 8;

    typedef logic [63:0]  t_hc_address;
    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [511:0] t_block;
    typedef logic [15:0]  t_ccip_mdata;

    typedef enum logic [2:0] {
        e_REQUEST_READ_STREAM   = 3'd0,
        e_REQUEST_WRITE_STREAM  = 3'd1,
        e_REQUEST_READ_INDEXED  = 3'd2,
        e_REQUEST_WRITE_INDEXED = 3'd3
    } t_request_cmd;

    typedef struct packed {
        t_request_cmd cmd;
        logic [7:0]   id;
        logic [31:0]  size;
        logic [31:0]  offset;
    } t_request_control;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'd0,
        eCL_LEN_2 = 2'd1,
        eCL_LEN_4 = 2'd3
    } t_ccip_clLen;

    typedef enum logic [1:0] {
        eVC_VA  = 2'd0,
        eVC_VL0 = 2'd1,
        eVC_VH0 = 2'd2,
        eVC_VH1 = 2'd3
    } t_ccip_vc;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_block             data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef enum logic [1:0] {
        S_RD_START  = 2'd0,
        S_RD_IDLE   = 2'd1,
        S_RD_STREAM = 2'd2,
        S_RD_INDEX  = 2'd3
    } t_rd_state;

    // Cache-line address of (byte base + line offset); wraps silently at 2^42 lines.
    function automatic t_ccip_clAddr hc_line_addr(input t_hc_address base, input logic [31:0] offset);
        logic [57:0] line;
        line = base[63:6] + 58'(offset);
        return line[41:0];
    endfunction

endpackage

// File: rtl/hc_rd_stream_requestor_if.sv
// Request, CCI-P c0 and line-output signals of the read requestor.
// master = requestor side, slave = CSR/CCI-P/accelerator side.
interface hc_rd_stream_requestor_if;
    import hc_rd_stream_requestor_pkg::*;

    logic             start;
    t_hc_address      buf_base;
    logic             req_valid;
    t_request_control req_ctl;
    logic             req_ready;
    t_if_ccip_c0_Tx   c0_tx;
    logic             c0_almfull;
    t_if_ccip_c0_Rx   c0_rx;
    logic             out_valid;
    t_block           out_data;
    logic             out_ready;
    logic             done;

    modport master (
        input  start, buf_base, req_valid, req_ctl, c0_almfull, c0_rx, out_ready,
        output req_ready, c0_tx, out_valid, out_data, done
    );

    modport slave (
        output start, buf_base, req_valid, req_ctl, c0_almfull, c0_rx, out_ready,
        input  req_ready, c0_tx, out_valid, out_data, done
    );

endinterface

// File: rtl/hc_rd_stream_requestor_rob.sv
// Reorder buffer: line storage indexed by tag, per-slot valid bits,
// one write port for responses and one head read port for retirement.
module hc_rd_rob
    import hc_rd_stream_requestor_pkg::*;
#(
    parameter int MAX_OUTSTANDING = HC_RD_MAX_OUTSTANDING,
    parameter int TAG_W           = $clog2(MAX_OUTSTANDING)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  t_block           i_wr_data,
    input  logic [TAG_W-1:0] i_rd_tag,
    input  logic             i_rd_clr,
    output logic             o_rd_valid,
    output t_block           o_rd_data
);

    t_block                     r_mem [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_tag] <= i_wr_data;
    end

    // Set and clear never target the same slot: the credit limit prevents tag reuse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            if (i_rd_clr) r_valid[i_rd_tag] <= 1'b0;
            if (i_wr_en)  r_valid[i_wr_tag] <= 1'b1;
        end
    end

    assign o_rd_valid = r_valid[i_rd_tag];
    assign o_rd_data  = r_mem[i_rd_tag];

endmodule

// File: rtl/hc_rd_stream_requestor.sv
// Read requestor: turns stream/indexed read commands into CCI-P c0 line reads
// and returns the out-of-order responses to the accelerator in line order.
module hc_rd_stream_requestor
    import hc_rd_stream_requestor_pkg::*;
#(
    parameter int MAX_OUTSTANDING = HC_RD_MAX_OUTSTANDING,
    parameter int TAG_W           = $clog2(MAX_OUTSTANDING)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    hc_rd_stream_requestor_if.master        io_bus
);

    t_rd_state          r_state;
    logic [31:0]        r_len;
    logic [31:0]        r_issued;
    logic [31:0]        r_retired;
    t_ccip_clAddr       r_base_cl;
    t_if_ccip_c0_Tx     r_c0_tx;
    logic               r_done;

    logic               w_accept;
    logic               w_cmd_read;
    logic [31:0]        w_cmd_len;
    logic               w_active;
    logic [31:0]        w_cur_len;
    logic [31:0]        w_cur_issued;
    logic [31:0]        w_cur_retired;
    t_ccip_clAddr       w_cur_base;
    logic [31:0]        w_inflight;
    logic               w_issue;
    t_ccip_c0_ReqMemHdr w_hdr;
    logic               w_rsp_wr;
    logic               w_head_valid;
    t_block             w_head_data;
    logic               w_retire;
    logic               w_unused;

    assign w_accept = (r_state == S_RD_IDLE) && io_bus.req_valid;

    always_comb begin
        w_cmd_read = 1'b0;
        w_cmd_len  = '0;
        case (io_bus.req_ctl.cmd)
            e_REQUEST_READ_STREAM:  begin w_cmd_read = 1'b1; w_cmd_len = io_bus.req_ctl.size; end
            e_REQUEST_READ_INDEXED: begin w_cmd_read = 1'b1; w_cmd_len = 32'd1; end
            default: ;
        endcase
    end

    // Issue logic sees the command being accepted as if it were already loaded,
    // so the first request leaves the cycle after accept.
    always_comb begin
        w_active      = (r_state == S_RD_STREAM);
        w_cur_len     = r_len;
        w_cur_issued  = r_issued;
        w_cur_retired = r_retired;
        w_cur_base    = r_base_cl;
        if (w_accept) begin
            w_active      = w_cmd_read && (w_cmd_len != '0);
            w_cur_len     = w_cmd_len;
            w_cur_issued  = '0;
            w_cur_retired = '0;
            w_cur_base    = hc_line_addr(io_bus.buf_base, io_bus.req_ctl.offset);
        end
        w_inflight = w_cur_issued - w_cur_retired;
        w_issue    = w_active && (w_cur_issued < w_cur_len) && !io_bus.c0_almfull
                     && (w_inflight < 32'(MAX_OUTSTANDING));

        w_hdr          = '0;
        w_hdr.vc_sel   = eVC_VA;
        w_hdr.cl_len   = eCL_LEN_1;
        w_hdr.req_type = eREQ_RDLINE_I;
        w_hdr.address  = w_cur_base + 42'(w_cur_issued);
        w_hdr.mdata    = 16'(w_cur_issued[TAG_W-1:0]);
    end

    assign w_rsp_wr = (r_state == S_RD_STREAM) && io_bus.c0_rx.rspValid
                      && (io_bus.c0_rx.hdr.resp_type == eRSP_RDLINE);
    assign w_retire = (r_state == S_RD_STREAM) && w_head_valid && io_bus.out_ready;

    hc_rd_rob #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .TAG_W           (TAG_W)
    ) u_rob (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_rsp_wr),
        .i_wr_tag   (io_bus.c0_rx.hdr.mdata[TAG_W-1:0]),
        .i_wr_data  (io_bus.c0_rx.data),
        .i_rd_tag   (r_retired[TAG_W-1:0]),
        .i_rd_clr   (w_retire),
        .o_rd_valid (w_head_valid),
        .o_rd_data  (w_head_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RD_START;
            r_len     <= '0;
            r_issued  <= '0;
            r_retired <= '0;
            r_base_cl <= '0;
            r_c0_tx   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_c0_tx.valid <= w_issue;
            if (w_issue) begin
                r_c0_tx.hdr <= w_hdr;
                r_issued    <= w_cur_issued + 32'd1;
            end
            case (r_state)
                S_RD_START: begin
                    if (io_bus.start) r_state <= S_RD_IDLE;
                end
                S_RD_IDLE: begin
                    if (w_accept) begin
                        r_len     <= w_cmd_len;
                        r_retired <= '0;
                        r_base_cl <= w_cur_base;
                        if (!w_issue) r_issued <= '0;
                        // Zero-length reads finish immediately; other commands are dropped.
                        if (w_cmd_read) begin
                            if (w_cmd_len == '0) r_done  <= 1'b1;
                            else                 r_state <= S_RD_STREAM;
                        end
                    end
                end
                S_RD_STREAM: begin
                    if (w_retire) begin
                        r_retired <= r_retired + 32'd1;
                        if (r_retired + 32'd1 == r_len) begin
                            r_done  <= 1'b1;
                            r_state <= S_RD_IDLE;
                        end
                    end
                end
                default: r_state <= S_RD_IDLE;
            endcase
        end
    end

    assign io_bus.req_ready = (r_state == S_RD_IDLE);
    assign io_bus.c0_tx     = r_c0_tx;
    assign io_bus.out_valid = (r_state == S_RD_STREAM) && w_head_valid;
    assign io_bus.out_data  = w_head_data;
    assign io_bus.done      = r_done;

    assign w_unused = ^{io_bus.req_ctl.id, io_bus.c0_rx.hdr.vc_used, io_bus.c0_rx.hdr.rsvd1,
                        io_bus.c0_rx.hdr.hit_miss, io_bus.c0_rx.hdr.rsvd0, io_bus.c0_rx.hdr.cl_num,
                        io_bus.c0_rx.hdr.mdata[15:TAG_W], io_bus.c0_rx.mmioRdValid,
                        io_bus.c0_rx.mmioWrValid};

endmodule

// File: tb/tb_hc_rd_stream_requestor.sv
// Bench for hc_rd_stream_requestor: directed and random commands against a
// line-level model of issue credits, response arrival and in-order retirement.
module tb_hc_rd_stream_requestor;
    import hc_rd_stream_requestor_pkg::*;

    localparam int MAXO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hc_rd_stream_requestor_if bus();

    hc_rd_stream_requestor #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int g_order[$];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] line_data(input logic [41:0] a);
        return {8{22'h15A5A5, a}};
    endfunction

    task automatic idle_inputs();
        bus.req_valid  = 1'b0;
        bus.req_ctl    = '0;
        bus.buf_base   = '0;
        bus.c0_almfull = 1'b0;
        bus.c0_rx      = '0;
        bus.out_ready  = 1'b0;
    endtask

    task automatic run_cmd(input t_request_cmd cmd, input logic [63:0] base, input logic [31:0] size,
                           input logic [31:0] offs, input int ready_pct, input int hold_ready,
                           input int af_start, input int af_len, input int af_pct, input int exp_stall);
        logic [41:0] addr_q[$];
        bit          arrived[$];
        int          pend_line[$];
        bit          rd, busy, exp_tx, exp_ov, exp_done_next, af, rdy;
        int          len, issued_m, retired_m, ret_before, tx_line, tx_seen, done_seen;
        int          idle_cyc, cyc, k, pick, ln;

        rd  = (cmd == e_REQUEST_READ_STREAM) || (cmd == e_REQUEST_READ_INDEXED);
        len = (cmd == e_REQUEST_READ_STREAM) ? int'(size) : (cmd == e_REQUEST_READ_INDEXED) ? 1 : 0;
        for (int i = 0; i < len; i++) begin
            addr_q.push_back(42'((base >> 6) + 64'(offs) + 64'(i)));
            arrived.push_back(1'b0);
        end
        issued_m = 0; retired_m = 0; tx_line = 0; tx_seen = 0; done_seen = 0; idle_cyc = 0;
        exp_tx = 1'b0; exp_ov = 1'b0; exp_done_next = 1'b0;

        k = 0;
        while (!bus.req_ready && k < 50) begin tick(); k++; end
        check("req_ready_before_cmd", bus.req_ready, 1'b1);

        bus.req_valid          = 1'b1;
        bus.req_ctl.cmd        = cmd;
        bus.req_ctl.id         = 8'($urandom);
        bus.req_ctl.size       = size;
        bus.req_ctl.offset     = offs;
        bus.buf_base           = base;
        busy = rd && (len > 0);

        for (cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) begin
                tick();
                check("tx_valid", bus.c0_tx.valid, exp_tx);
                if (bus.c0_tx.valid) tx_seen++;
                if (exp_tx) begin
                    check("tx_addr", bus.c0_tx.hdr.address, addr_q[tx_line]);
                    check("tx_mdata", bus.c0_tx.hdr.mdata, 16'(tx_line % MAXO));
                    check("tx_type", bus.c0_tx.hdr.req_type, eREQ_RDLINE_I);
                    check("tx_len", bus.c0_tx.hdr.cl_len, eCL_LEN_1);
                    pend_line.push_back(tx_line);
                end
                exp_ov = (retired_m < len) ? arrived[retired_m] : 1'b0;
                check("out_valid", bus.out_valid, exp_ov);
                if (exp_ov) check("out_data", bus.out_data, line_data(addr_q[retired_m]));
                check("done", bus.done, exp_done_next);
                if (bus.done) done_seen++;
                check("req_ready", bus.req_ready, !busy);
                if (exp_stall >= 0 && cyc == hold_ready) check("stall_issue_count", tx_seen, exp_stall);
                if (!busy) idle_cyc++;
                if (idle_cyc >= 3) break;
                bus.req_valid = 1'b0;
            end

            rdy = (cyc >= hold_ready) && (int'($urandom_range(99)) < ready_pct);
            bus.out_ready = rdy;
            exp_done_next = (cyc == 0) && rd && (len == 0);
            ret_before = retired_m;
            if (exp_ov && rdy) begin
                retired_m++;
                if (retired_m == len) begin busy = 1'b0; exp_done_next = 1'b1; end
            end

            af = (cyc >= af_start && cyc < af_start + af_len) || (int'($urandom_range(99)) < af_pct);
            bus.c0_almfull = af;

            bus.c0_rx = '0;
            pick = -1;
            if (g_order.size() > 0) begin
                foreach (pend_line[j]) if (pend_line[j] == g_order[0]) pick = j;
                if (pick >= 0) void'(g_order.pop_front());
            end else if (pend_line.size() > 0 && $urandom_range(99) < 60) begin
                pick = int'($urandom_range(pend_line.size() - 1));
            end
            if (pick >= 0) begin
                ln = pend_line[pick];
                pend_line.delete(pick);
                bus.c0_rx.rspValid      = 1'b1;
                bus.c0_rx.hdr.resp_type = eRSP_RDLINE;
                bus.c0_rx.hdr.mdata     = 16'(ln % MAXO);
                bus.c0_rx.data          = line_data(addr_q[ln]);
                arrived[ln] = 1'b1;
            end else if ($urandom_range(99) < 10) begin
                bus.c0_rx.rspValid      = 1'b1;
                bus.c0_rx.hdr.resp_type = eRSP_UMSG;
                bus.c0_rx.hdr.mdata     = 16'($urandom_range(MAXO - 1));
                bus.c0_rx.data          = {16{$urandom}};
            end

            exp_tx  = busy && (issued_m < len) && !af && (issued_m - ret_before < MAXO);
            tx_line = issued_m;
            if (exp_tx) issued_m++;
        end

        if (cyc >= 3000) check("cmd_timeout", 1'b0, 1'b1);
        check("done_count", done_seen, rd ? 1 : 0);
        check("tx_count", tx_seen, len);
        idle_inputs();
        g_order.delete();
    endtask

    initial begin
        int n, k;
        logic [63:0] base;

        idle_inputs();
        bus.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_tx_valid", bus.c0_tx.valid, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_done", bus.done, 1'b0);
        rst_n = 1'b1;
        tick(); tick();
        check("no_start_req_ready", bus.req_ready, 1'b0);
        bus.start = 1'b1;
        tick();
        check("start_req_ready", bus.req_ready, 1'b1);

        // Responses returned in order 3,1,0,2.
        g_order = '{3, 1, 0, 2};
        run_cmd(e_REQUEST_READ_STREAM, 64'h1000, 32'd4, 32'd0, 100, 0, 0, 0, 0, -1);
        // Output blocked: issue stalls at the credit limit.
        run_cmd(e_REQUEST_READ_STREAM, 64'h40_0000, 32'd20, 32'd3, 100, 30, 0, 0, 0, 8);
        // Almost-full window mid-stream.
        run_cmd(e_REQUEST_READ_STREAM, 64'h2_0000, 32'd12, 32'd5, 100, 0, 4, 5, 0, -1);
        run_cmd(e_REQUEST_READ_INDEXED, 64'h0012_3456_7000, 32'd9, 32'd7, 100, 0, 0, 0, 0, -1);
        run_cmd(e_REQUEST_READ_STREAM, 64'h3000, 32'd0, 32'd2, 100, 0, 0, 0, 0, -1);
        run_cmd(e_REQUEST_WRITE_STREAM, 64'h3000, 32'd6, 32'd0, 100, 0, 0, 0, 0, -1);
        // Line address wraps at 2^42.
        run_cmd(e_REQUEST_READ_STREAM, 64'hFFFF_FFFF_FFFF_FF80, 32'd5, 32'd0, 70, 0, 0, 0, 10, -1);
        for (int r = 0; r < 6; r++) begin
            base = {$urandom, $urandom};
            run_cmd(e_REQUEST_READ_STREAM, base, 32'($urandom_range(24, 1)), 32'($urandom_range(1000)),
                    int'($urandom_range(100, 30)), 0, 0, 0, 10, -1);
        end

        // Reset with three reads outstanding; a late response must be ignored.
        k = 0;
        while (!bus.req_ready && k < 50) begin tick(); k++; end
        bus.req_valid      = 1'b1;
        bus.req_ctl        = '0;
        bus.req_ctl.cmd    = e_REQUEST_READ_STREAM;
        bus.req_ctl.size   = 32'd8;
        bus.buf_base       = 64'h8000;
        n = 0; k = 0;
        while (n < 3 && k < 20) begin
            tick();
            bus.req_valid = 1'b0;
            if (bus.c0_tx.valid) n++;
            k++;
        end
        check("rst_setup_tx", n, 3);
        rst_n = 1'b0;
        bus.start = 1'b0;
        #1;
        check("midrst_req_ready", bus.req_ready, 1'b0);
        check("midrst_tx_valid", bus.c0_tx.valid, 1'b0);
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        bus.c0_rx.rspValid      = 1'b1;
        bus.c0_rx.hdr.resp_type = eRSP_RDLINE;
        bus.c0_rx.hdr.mdata     = 16'd0;
        bus.c0_rx.data          = line_data(42'h200);
        tick();
        bus.c0_rx = '0;
        for (int i = 0; i < 4; i++) begin
            check("late_rsp_out_valid", bus.out_valid, 1'b0);
            check("late_rsp_req_ready", bus.req_ready, 1'b0);
            check("late_rsp_tx_valid", bus.c0_tx.valid, 1'b0);
            tick();
        end
        bus.start = 1'b1;
        tick();
        check("restart_req_ready", bus.req_ready, 1'b1);
        check("restart_out_valid", bus.out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hc_rd_stream_requestor.md
# hc_rd_stream_requestor

Read requestor between the HardCloud request interface (`t_request_control`) and the CCI-P c0 channel. It turns a read-stream or read-indexed command against one host buffer into cache-line read requests. It reorders the out-of-order CCI-P responses and delivers lines to the accelerator strictly in line order over a valid/ready port. It sits directly downstream of the CSR buffer-descriptor registers and upstream of the accelerator's RX buffer FIFO.

## Interface
- `MAX_OUTSTANDING`, 8: reads in flight and reorder depth; power of two, 2..64.
- `TAG_W`, $clog2(MAX_OUTSTANDING): reorder tag width, carried in `mdata[TAG_W-1:0]`.
- `clk`  in  1  the only clock; CCI-P pClk domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level from the CSR block; high once `HC_CONTROL_START` is written.
- `buf_base`  in  64  byte address of the selected buffer (`t_hc_address`). Captured on request accept.
- `req_valid`  in  1  command present.
- `req_ctl`  in  `t_request_control`  fields `cmd`, `id`, `size` (lines), `offset` (lines).
- `req_ready`  out  1  command accepted when high with `req_valid`.
- `c0_tx`  out  `t_if_ccip_c0_Tx`  read request; `eREQ_RDLINE_I`, single-line length.
- `c0_almfull`  in  1  `c0TxAlmFull`.
- `c0_rx`  in  `t_if_ccip_c0_Rx`  read response.
- `out_valid`  out  1  line available.
- `out_data`  out  512  `t_block` payload.
- `out_ready`  in  1  consumer takes the line.
- `done`  out  1  one-cycle pulse when the last line of a command has been retired.

## Operation
- States (`t_rd_state`): `S_RD_START` → `S_RD_IDLE` when `start`=1. `S_RD_IDLE` → `S_RD_STREAM` on accept.
- In `S_RD_STREAM`, return to `S_RD_IDLE` with `done` once issued == retired == length. `S_RD_INDEX` is not used; reaching it returns to `S_RD_IDLE`.
- `req_ready` = (state == `S_RD_IDLE`). Accepted commands:
  - `e_REQUEST_READ_STREAM`: length = `size`.
  - `e_REQUEST_READ_INDEXED`: length = 1, line at `offset`.
- Any other `cmd` is accepted and dropped without `done`. `id` is ignored.
- Line address = `buf_base[63:6] + offset + i`, truncated to `t_ccip_clAddr` (42 b). Wrap at 2^42 is silent.
- Counters: `issued` and `retired` are 32 b, cleared on accept.
- Issue condition, at most one request per cycle: `issued < length`, `!c0_almfull`, and `issued - retired < MAX_OUTSTANDING`.
- Tag = `issued[TAG_W-1:0]`; `mdata` upper bits are 0.
- Response handling:
  - `rspValid` with `resp_type == eRSP_RDLINE` writes data into ROB slot `mdata[TAG_W-1:0]` and sets its valid bit.
  - A response that is not a read, or any response received in `S_RD_START`/`S_RD_IDLE`, is dropped.
- Retire: the head slot `retired[TAG_W-1:0]` drives `out_*`. On `out_valid & out_ready`, clear that slot's bit and increment `retired`.
- Length 0: `done` pulses 1 cycle after accept; no requests are issued.
- `start` falling mid-command does not abort the command. Only `rst_n` aborts.

## Timing
- Reset values: `req_ready`=0 (state `S_RD_START`), `c0_tx.valid`=0, `out_valid`=0, `done`=0. All ROB valid bits and counters are 0.
- `c0_tx` is registered. The first request is valid the cycle after accept.
- `c0_almfull` is sampled in the cycle the request is formed; no request is issued in the cycle after `c0_almfull` is high.
- Response to `out_valid`: 1 cycle (ROB write, then registered head). The ROB is two-port: write and read in the same cycle are allowed.
- `out_data` holds stable while `out_valid & !out_ready`.
- `done` is asserted in the cycle after the final retire handshake. `req_ready` rises in the same cycle.
- A response arriving in the same cycle as a retire on a different slot is handled in that cycle. Responses to the same slot cannot coincide, because the credit rule prevents tag reuse.
- Async reset mid-command clears everything. Late responses are then dropped in `S_RD_START`.

## Structure
- Add to `hc_pkg`: `t_rd_state` (already present), a `HC_RD_MAX_OUTSTANDING` default constant, and an `hc_line_addr(base, offset)` function.
- Sub-module `hc_rd_rob`: `MAX_OUTSTANDING`×512 storage, a valid-bit vector, a write port (tag) and a head read port. The top level holds the FSM, counters and CCI-P formatting.

## Test plan
- Stream with base 0x1000, size 4, offset 0; responses returned in order 3,1,0,2 → requests to lines 0x40..0x43 with tags 0..3. `out_data` emerges in order 0,1,2,3; `done` pulses once.
- Stream of size 20 with `MAX_OUTSTANDING`=8 and `out_ready`=0 → exactly 8 requests, then issue stalls. Releasing `out_ready` lets all 20 lines complete in order.
- `c0_almfull` held high for 5 cycles mid-stream → no `c0_tx.valid` in those cycles plus 1; the address sequence has no gaps.
- Indexed command with offset 7 and size 9 → a single request to line `base/64`+7, followed by one output and `done`.
- Size 0 → no requests; `done` pulses 1 cycle after accept. `cmd`=`e_REQUEST_WRITE_STREAM` → accepted, no `done`, returns to idle.
- `rst_n` low with 3 reads outstanding, then a response arrives after release → no `out_valid`; `req_ready` stays 0 until `start`.
